// File: rtl/rns_decomp_scheduler.sv
// rns_decomp_scheduler
// Shares one external combinational Barrett reducer among NREQ requesters.
// A granted wide operand is swept across a software-programmed table of
// PARTS moduli; each result is streamed out as a tagged residue over a
// valid/ready interface, in index order, one operand at a time.
// Optional build macro: RNS_SCHED_ERRCHK_EN adds a sticky err output that
// flags zero moduli, either at capture or on a table write.
module rns_decomp_scheduler #(
  parameter int LWIDTH = 64,
  parameter int SWIDTH = 32,
  parameter int PARTS  = 4,
  parameter int NREQ   = 2,
  localparam int IW    = (PARTS > 1) ? $clog2(PARTS) : 1,
  localparam int SW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*LWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   mod_wr_en,
  input  logic [IW-1:0]          mod_wr_idx,
  input  logic [SWIDTH-1:0]      mod_wr_data,
  output logic [LWIDTH-1:0]      br_a,
  output logic [SWIDTH-1:0]      br_q,
  input  logic [SWIDTH-1:0]      br_mod,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SWIDTH-1:0]      res_data,
  output logic [IW-1:0]          res_idx,
  output logic [SW-1:0]          res_src,
  output logic                   res_last,
  output logic                   busy
`ifdef RNS_SCHED_ERRCHK_EN
  ,
  output logic                   err
`endif
);

  localparam int IW1 = IW + 1;
  localparam logic [IW-1:0] K_LAST  = IW'(PARTS - 1);
  localparam logic [IW1-1:0] PARTS_V = IW1'(PARTS);
  localparam logic [SW-1:0] RR_INIT = SW'(NREQ - 1);

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t            state;
  logic [IW-1:0]     k;
  logic [SWIDTH-1:0] qtab [PARTS];
  logic [LWIDTH-1:0] op;
  logic [SW-1:0]     src;
  logic [SW-1:0]     rr_last;

  logic [SW-1:0]     grant;
  logic [SW-1:0]     grant_hi;
  logic [SW-1:0]     grant_lo;
  logic              found_hi;
  logic              grant_any;
  logic [LWIDTH-1:0] grant_data;
  logic              accept;
  logic              capture;
  logic              wr_ok;

  // Round-robin arbiter: the lowest valid index above rr_last wins,
  // otherwise wrap around to the lowest valid index overall.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_lo = SW'(i);
        if (i > int'(rr_last)) begin
          grant_hi = SW'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant     = found_hi ? grant_hi : grant_lo;
    grant_any = |req_valid;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == SW'(i)) grant_data = req_data[i*LWIDTH +: LWIDTH];
    end
  end

  // Accept strobe goes only to the granted requester, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any) req_ready[grant] = 1'b1;
  end

  assign accept  = (state == IDLE) && grant_any;
  assign capture = (state == COMPUTE) && (!res_valid || res_ready);
  assign wr_ok   = mod_wr_en && (state == IDLE) && !grant_any &&
                   ({1'b0, mod_wr_idx} < PARTS_V);

  assign br_a = op;
  assign br_q = qtab[k];
  assign busy = (state == COMPUTE);

  // Sweep FSM, modulus table and registered residue output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      op        <= '0;
      src       <= '0;
      rr_last   <= RR_INIT;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_src   <= '0;
      res_last  <= 1'b0;
      for (int i = 0; i < PARTS; i++) qtab[i] <= '0;
`ifdef RNS_SCHED_ERRCHK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op      <= grant_data;
            src     <= grant;
            rr_last <= grant;
            k       <= '0;
            state   <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (capture) begin
            if (k == K_LAST) state <= IDLE;
            else k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (capture) begin
        res_valid <= 1'b1;
        res_idx   <= k;
        res_src   <= src;
        res_last  <= (k == K_LAST);
`ifdef RNS_SCHED_ERRCHK_EN
        if (br_q == '0) begin
          res_data <= '0;
          err      <= 1'b1;
        end else begin
          res_data <= br_mod;
        end
`else
        res_data  <= br_mod;
`endif
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      if (wr_ok) begin
`ifdef RNS_SCHED_ERRCHK_EN
        if (mod_wr_data == '0) err <= 1'b1;
        else qtab[mod_wr_idx] <= mod_wr_data;
`else
        qtab[mod_wr_idx] <= mod_wr_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rns_decomp_scheduler.sv
// Testbench for rns_decomp_scheduler: acts as the Barrett reducer and the
// requesters, collects every residue handshake and compares against a table
// of hand-computed residues, plus timing sequences for the corner cases.
module tb_rns_decomp_scheduler;

  localparam int LWIDTH = 64;
  localparam int SWIDTH = 32;
  localparam int PARTS  = 4;
  localparam int NREQ   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*LWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   mod_wr_en;
  logic [1:0]             mod_wr_idx;
  logic [SWIDTH-1:0]      mod_wr_data;
  logic [LWIDTH-1:0]      br_a;
  logic [SWIDTH-1:0]      br_q;
  logic [SWIDTH-1:0]      br_mod;
  logic                   res_valid;
  logic                   res_ready;
  logic [SWIDTH-1:0]      res_data;
  logic [1:0]             res_idx;
  logic [0:0]             res_src;
  logic                   res_last;
  logic                   busy;
`ifdef RNS_SCHED_ERRCHK_EN
  logic                   err;
`endif

  logic [LWIDTH-1:0] req_ops [NREQ];
  logic [LWIDTH-1:0] rem_wide;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [SWIDTH-1:0] data;
    logic [1:0]        idx;
    logic [0:0]        src;
    logic              last;
  } res_t;

  typedef struct packed {
    logic [0:0]                   src;
    logic [LWIDTH-1:0]            operand;
    logic [PARTS-1:0][SWIDTH-1:0] exp;
  } vec_t;

  vec_t vecs [8];
  res_t resq [$];

  rns_decomp_scheduler #(
    .LWIDTH(LWIDTH), .SWIDTH(SWIDTH), .PARTS(PARTS), .NREQ(NREQ)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .mod_wr_en(mod_wr_en), .mod_wr_idx(mod_wr_idx), .mod_wr_data(mod_wr_data),
    .br_a(br_a), .br_q(br_q), .br_mod(br_mod),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_src(res_src), .res_last(res_last),
    .busy(busy)
`ifdef RNS_SCHED_ERRCHK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  assign req_data = {req_ops[1], req_ops[0]};

  // Reference reducer: plain modulo, zero modulus returns zero.
  always_comb begin
    rem_wide = '0;
    if (br_q != '0) rem_wide = br_a % {{(LWIDTH-SWIDTH){1'b0}}, br_q};
    br_mod = rem_wide[SWIDTH-1:0];
  end

  // Record each residue that will be handed over at the next rising edge.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready)
      resq.push_back({res_data, res_idx, res_src, res_last});
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic setVec(input int i, input logic [0:0] s, input logic [63:0] opd,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] e3);
    vecs[i].src     = s;
    vecs[i].operand = opd;
    vecs[i].exp[0]  = e0;
    vecs[i].exp[1]  = e1;
    vecs[i].exp[2]  = e2;
    vecs[i].exp[3]  = e3;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeMod(input logic [1:0] idx, input logic [31:0] data);
    mod_wr_en   = 1'b1;
    mod_wr_idx  = idx;
    mod_wr_data = data;
    nextCycle();
    mod_wr_en   = 1'b0;
  endtask

  // Present an operand on one requester and hold it until accepted.
  task automatic applyStimulus(input logic [0:0] src, input logic [63:0] operand);
    bit acked = 1'b0;
    req_ops[src]   = operand;
    req_valid[src] = 1'b1;
    for (int c = 0; c < 100 && !acked; c++) begin
      @(negedge clk);
      if (req_ready[src]) acked = 1'b1;
      nextCycle();
    end
    req_valid[src] = 1'b0;
    checkOutput("ack_seen", acked, 1);
  endtask

  task automatic waitResidues(input int n);
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (resq.size() >= n && !busy && !res_valid) done = 1'b1;
      nextCycle();
    end
    checkOutput("drain_done", done, 1);
    checkOutput("residue_count", resq.size(), n);
  endtask

  task automatic checkResidues(input int vi);
    res_t r;
    for (int p = 0; p < PARTS; p++) begin
      if (resq.size() == 0) begin
        checkOutput($sformatf("v%0d_missing%0d", vi, p), 0, 1);
      end else begin
        r = resq.pop_front();
        checkOutput($sformatf("v%0d_data%0d", vi, p), r.data, vecs[vi].exp[p]);
        checkOutput($sformatf("v%0d_idx%0d", vi, p), r.idx, p);
        checkOutput($sformatf("v%0d_src%0d", vi, p), r.src, vecs[vi].src);
        checkOutput($sformatf("v%0d_last%0d", vi, p), r.last, (p == PARTS - 1));
      end
    end
  endtask

  initial begin
    logic [NREQ-1:0] g;
    int nacc;
    int p0;
    int p1;

    // Moduli 97, 193, 257, 65537 unless noted.
    setVec(0, 1'b0, 64'd1000000,       32'd27,  32'd67,  32'd13,  32'd16945);
    setVec(1, 1'b1, 64'd123456789,     32'd39,  32'd93,  32'd157, 32'd50618);
    setVec(2, 1'b0, 64'd200,           32'd6,   32'd7,   32'd200, 32'd200);
    setVec(3, 1'b1, 64'd300,           32'd9,   32'd107, 32'd43,  32'd300);
    setVec(4, 1'b0, 64'd1099511627776, 32'd36,  32'd49,  32'd256, 32'd256);
    setVec(5, 1'b1, 64'd131079,        32'd32,  32'd32,  32'd9,   32'd5);
    // Entry 0 reprogrammed to 101.
    setVec(6, 1'b0, 64'd1000000,       32'd100, 32'd67,  32'd13,  32'd16945);
    // Entry 2 left at zero after reset.
    setVec(7, 1'b0, 64'd1000000,       32'd27,  32'd67,  32'd0,   32'd16945);

    reset       = 1'b1;
    req_valid   = '0;
    req_ops[0]  = '0;
    req_ops[1]  = '0;
    mod_wr_en   = 1'b0;
    mod_wr_idx  = '0;
    mod_wr_data = '0;
    res_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_idx", res_idx, 0);
    checkOutput("rst_res_src", res_src, 0);
    checkOutput("rst_res_last", res_last, 0);
    checkOutput("rst_br_q", br_q, 0);
    nextCycle();

    writeMod(2'd0, 32'd97);
    writeMod(2'd1, 32'd193);
    writeMod(2'd2, 32'd257);
    writeMod(2'd3, 32'd65537);

    $display("[TB] single operand latency");
    req_ops[0]   = vecs[0].operand;
    req_valid[0] = 1'b1;
    @(negedge clk);
    checkOutput("accept_strobe", req_ready, 2'b01);
    nextCycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("t1_res_valid", res_valid, 0);
    checkOutput("t1_busy", busy, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_res_valid", res_valid, 1);
    checkOutput("t2_res_data", res_data, 27);
    nextCycle();
    waitResidues(4);
    checkResidues(0);

    $display("[TB] requester 1 alone");
    applyStimulus(1'b1, vecs[1].operand);
    waitResidues(4);
    checkResidues(1);

    $display("[TB] round robin with both requesters");
    p0 = 0;
    p1 = 0;
    nacc = 0;
    req_ops[0] = vecs[2].operand;
    req_ops[1] = vecs[3].operand;
    req_valid  = 2'b11;
    for (int c = 0; c < 200 && nacc < 4; c++) begin
      @(negedge clk);
      g = req_ready;
      nextCycle();
      if (g != '0) begin
        checkOutput($sformatf("rr_grant%0d", nacc), g, (nacc % 2 == 0) ? 2'b01 : 2'b10);
        nacc++;
        if (g[0]) begin
          p0++;
          if (p0 < 2) req_ops[0] = vecs[4].operand;
          else req_valid[0] = 1'b0;
        end
        if (g[1]) begin
          p1++;
          if (p1 < 2) req_ops[1] = vecs[5].operand;
          else req_valid[1] = 1'b0;
        end
      end
    end
    req_valid = '0;
    checkOutput("rr_accepts", nacc, 4);
    waitResidues(16);
    for (int v = 2; v <= 5; v++) checkResidues(v);

    $display("[TB] backpressure on residue 1");
    applyStimulus(1'b0, vecs[0].operand);
    nextCycle();
    nextCycle();
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_valid%0d", c), res_valid, 1);
      checkOutput($sformatf("bp_data%0d", c), res_data, 67);
      checkOutput($sformatf("bp_idx%0d", c), res_idx, 1);
      nextCycle();
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_data", res_data, 67);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_next_data", res_data, 13);
    checkOutput("bp_next_idx", res_idx, 2);
    nextCycle();
    waitResidues(4);
    checkResidues(0);

    $display("[TB] table writes during compute and accept");
    applyStimulus(1'b0, vecs[0].operand);
    writeMod(2'd0, 32'd101);
    waitResidues(4);
    checkResidues(0);
    req_ops[0]   = vecs[0].operand;
    req_valid[0] = 1'b1;
    mod_wr_en    = 1'b1;
    mod_wr_idx   = 2'd0;
    mod_wr_data  = 32'd101;
    @(negedge clk);
    checkOutput("wr_accept_strobe", req_ready, 2'b01);
    nextCycle();
    req_valid[0] = 1'b0;
    mod_wr_en    = 1'b0;
    waitResidues(4);
    checkResidues(0);
    writeMod(2'd0, 32'd101);
    applyStimulus(1'b0, vecs[6].operand);
    waitResidues(4);
    checkResidues(6);

    $display("[TB] reset mid operand");
    applyStimulus(1'b1, 64'd1000000);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_res_valid", res_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_br_q", br_q, 0);
    checkOutput("mid_rst_count", resq.size(), 1);
    nextCycle();
    repeat (6) nextCycle();
    @(negedge clk);
    checkOutput("mid_rst_quiet_count", resq.size(), 1);
    checkOutput("mid_rst_quiet_valid", res_valid, 0);
    nextCycle();
    resq.delete();
`ifdef RNS_SCHED_ERRCHK_EN
    checkOutput("err_after_reset", err, 0);
`endif

    writeMod(2'd0, 32'd97);
    writeMod(2'd1, 32'd193);
    writeMod(2'd3, 32'd65537);
    req_ops[0] = vecs[7].operand;
    req_ops[1] = 64'd123456789;
    req_valid  = 2'b11;
    @(negedge clk);
    checkOutput("post_rst_grant", req_ready, 2'b01);
    nextCycle();
    req_valid = '0;
    waitResidues(4);
    checkResidues(7);
`ifdef RNS_SCHED_ERRCHK_EN
    checkOutput("err_raised", err, 1);
    repeat (5) nextCycle();
    checkOutput("err_sticky", err, 1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
